// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction byte stream and (HL) memory read handshake
// between the alu_sequencer (slave) and its environment (master).
interface alu_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_data;
  logic        mem_rd_req;
  logic [15:0] mem_addr;
  logic        mem_rd_valid;
  logic [7:0]  mem_rd_data;

  modport master (
    output instr_valid,
    output instr_data,
    input  instr_ready,
    input  mem_rd_req,
    input  mem_addr,
    output mem_rd_valid,
    output mem_rd_data
  );

  modport slave (
    input  instr_valid,
    input  instr_data,
    output instr_ready,
    output mem_rd_req,
    output mem_addr,
    input  mem_rd_valid,
    input  mem_rd_data
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: decodes the 8-bit ALU group and LD r,n8, sequences the
// external ALU and writes result/flags back to the internal register file.
package gate_boy_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int FLAG_WIDTH = 8;
  typedef enum logic [2:0] {
    ADD, ADC, SUB, SBC, AND, XOR, OR, CP
  } instruction_t;
endpackage

module alu_sequencer
  import gate_boy_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_sequencer_if.slave        bus,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output instruction_t          alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [FLAG_WIDTH-1:0] alu_flags,
  output logic [DATA_WIDTH-1:0] reg_a,
  output logic [FLAG_WIDTH-1:0] reg_f,
  output logic                  busy,
  output logic                  illegal
);

  typedef enum logic [2:0] {
    S_FETCH, S_FETCH_IMM, S_MEM_RD, S_EXEC, S_WAIT, S_WB
  } state_t;

  localparam logic [7:0] LAT_M1 = 8'(ALU_LATENCY - 1);

  // Index 6 holds F, so register codes map directly (7 = A).
  state_t          r_state;
  logic [7:0]      r_rf [8];
  logic            r_ready;
  logic            r_req;
  logic            r_busy;
  logic            r_illegal;
  logic            r_ld;
  logic [2:0]      r_dst;
  instruction_t    r_op;
  logic [15:0]     r_addr;
  logic [7:0]      r_alu_a;
  logic [7:0]      r_alu_b;
  instruction_t    r_alu_op;
  logic [7:0]      r_cnt;

  logic       w_take;
  logic [7:0] w_byte;
  logic       w_grp;
  logic       w_imm;
  logic       w_ldi;
  logic       w_unused;

  assign w_byte = bus.instr_data;
  assign w_take = bus.instr_valid && r_ready;
  assign w_grp  = (w_byte[7:6] == 2'b10);
  assign w_imm  = (w_byte[7:6] == 2'b11) &&
                  (w_byte[2:0] == 3'b110);
  assign w_ldi  = (w_byte[7:6] == 2'b00) &&
                  (w_byte[2:0] == 3'b110) &&
                  (w_byte[5:3] != 3'd6);
  assign w_unused = ^alu_flags[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
      r_ready   <= 1'b1;
      r_req     <= 1'b0;
      r_busy    <= 1'b0;
      r_illegal <= 1'b0;
      r_ld      <= 1'b0;
      r_dst     <= '0;
      r_op      <= ADD;
      r_addr    <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= ADD;
      r_cnt     <= '0;
    end else begin
      r_illegal <= 1'b0;
      unique case (r_state)
        S_FETCH: begin
          if (w_take) begin
            unique case (1'b1)
              w_grp: begin
                r_op   <= instruction_t'(w_byte[5:3]);
                r_busy <= 1'b1;
                r_ready <= 1'b0;
                if (w_byte[2:0] == 3'd6) begin
                  r_req   <= 1'b1;
                  r_addr  <= {r_rf[4], r_rf[5]};
                  r_state <= S_MEM_RD;
                end else begin
                  r_alu_a  <= r_rf[7];
                  r_alu_b  <= r_rf[w_byte[2:0]];
                  r_alu_op <= instruction_t'(w_byte[5:3]);
                  r_state  <= S_EXEC;
                end
              end
              w_imm: begin
                r_op    <= instruction_t'(w_byte[5:3]);
                r_ld    <= 1'b0;
                r_busy  <= 1'b1;
                r_state <= S_FETCH_IMM;
              end
              w_ldi: begin
                r_dst   <= w_byte[5:3];
                r_ld    <= 1'b1;
                r_busy  <= 1'b1;
                r_state <= S_FETCH_IMM;
              end
              default: r_illegal <= 1'b1;
            endcase
          end
        end
        S_FETCH_IMM: begin
          if (w_take) begin
            if (r_ld) begin
              r_rf[r_dst] <= w_byte;
              r_busy      <= 1'b0;
              r_state     <= S_FETCH;
            end else begin
              r_alu_a  <= r_rf[7];
              r_alu_b  <= w_byte;
              r_alu_op <= r_op;
              r_ready  <= 1'b0;
              r_state  <= S_EXEC;
            end
          end
        end
        S_MEM_RD: begin
          if (bus.mem_rd_valid) begin
            r_req    <= 1'b0;
            r_alu_a  <= r_rf[7];
            r_alu_b  <= bus.mem_rd_data;
            r_alu_op <= r_op;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_cnt   <= LAT_M1;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == 8'd0) r_state <= S_WB;
          else r_cnt <= r_cnt - 8'd1;
        end
        S_WB: begin
          r_rf[6] <= {alu_flags[7:4], 4'b0000};
          if (r_alu_op != CP) r_rf[7] <= alu_result;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign bus.instr_ready = r_ready;
  assign bus.mem_rd_req  = r_req;
  assign bus.mem_addr    = r_addr;
  assign alu_a   = r_alu_a;
  assign alu_b   = r_alu_b;
  assign alu_op  = r_alu_op;
  assign reg_a   = r_rf[7];
  assign reg_f   = r_rf[6];
  assign busy    = r_busy;
  assign illegal = r_illegal;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Instruction-side driver of the Game Boy ALU: accepts opcode/immediate bytes over a valid/ready stream and decodes the 8-bit ALU group and LD r,n8.
- Presents operands and an instruction_t opcode to the ALU, then captures the registered result and flags one ALU latency later.
- Writes result and flags back to its internal register file (B,C,D,E,H,L,A,F) and fetches (HL) operands through a simple memory read handshake.

Parameters:
- DATA_WIDTH, 8, byte width, from gate_boy_pkg.
- FLAG_WIDTH, 8, F register width; Z=7, N=6, H=5, C=4, bits 3:0 always 0.
- ALU_LATENCY, 1, clk cycles from alu_op presented to alu_result/alu_flags valid.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- instr_valid  in  1  instr_data valid
- instr_ready  out  1  sequencer accepts byte this cycle
- instr_data  in  8  opcode or immediate byte
- mem_rd_req  out  1  (HL) read request, held until mem_rd_valid
- mem_addr  out  16  {H,L}
- mem_rd_valid  in  1  mem_rd_data valid (1-cycle pulse)
- mem_rd_data  in  8  read byte
- alu_a  out  8  operand A (always register A)
- alu_b  out  8  operand B
- alu_op  out  instruction_t  ADD/ADC/SUB/SBC/AND/XOR/OR/CP
- alu_result  in  8  ALU result
- alu_flags  in  8  ALU flags
- reg_a  out  8  architectural A
- reg_f  out  8  architectural F
- busy  out  1  high in any state except FETCH
- illegal  out  1  1-cycle pulse on unsupported opcode

Behaviour:
- Reset: all registers 0x00; state FETCH; instr_ready=1, mem_rd_req=0, illegal=0, busy=0, alu_a/alu_b=0, alu_op=ADD. Reset mid-instruction aborts it with no writeback; a pending memory request is dropped.
- States: FETCH, FETCH_IMM, MEM_RD, EXEC, WAIT, WB.
- FETCH: instr_ready=1; a byte is accepted on instr_valid&&instr_ready.
  - 0x80-0xBF: op=bits[5:3] (0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP), src=bits[2:0] (0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 (HL), 7 A). src 6 -> MEM_RD, else -> EXEC.
  - 0xC6/CE/D6/DE/E6/EE/F6/FE: same op field -> FETCH_IMM.
  - 00rrr110 with rrr!=6: LD r,n8 -> FETCH_IMM.
  - Anything else: illegal pulses next cycle, no state change, stay in FETCH.
- FETCH_IMM: instr_ready=1. Next accepted byte either becomes operand B (-> EXEC) or, for LD, is written to r (-> FETCH). The ALU is not used for LD.
- MEM_RD: mem_rd_req=1, mem_addr={H,L} held stable. The mem_rd_valid cycle latches operand B -> EXEC.
- EXEC: drives alu_a=A, alu_b, alu_op for exactly one cycle -> WAIT. Operands and op are held stable through WAIT.
- WAIT: ALU_LATENCY cycles, counted by a down-counter -> WB.
- WB: samples alu_result/alu_flags. F<={alu_flags[7:4],4'b0}; A<=alu_result unless CP. -> FETCH.
- instr_ready=0 in MEM_RD, EXEC, WAIT, WB; bytes presented then are not consumed.
- Registers update only on the clk edges above. reg_a/reg_f reflect committed state; WB is visible on the following cycle.
- ADC/SBC carry-in comes from F.C via the ALU (the ALU reads flags internally). The sequencer never modifies F outside WB.
- Throughput: register-source op takes 4 cycles (FETCH, EXEC, WAIT, WB) at ALU_LATENCY=1.

Test Plan:
- LD A,0x3A (06... use 3E 3A); LD B,0xC6 (06 C6); ADD A,B (80) -> reg_a=0x00, reg_f=0xB0, illegal never asserted.
- A=0x10; CP 0x10 (FE 10) -> reg_a stays 0x10, reg_f=0xC0.
- H=0xC0, L=0x12, A=0x0F; XOR (HL) (AE), memory returns 0xFF after 3 cycles -> mem_addr=0xC012 and mem_rd_req held until valid, reg_a=0xF0, reg_f=0x00.
- Opcode 0x00, then 0x76 -> two illegal pulses, registers unchanged, instr_ready stays 1.
- instr_valid toggling 1/0 between opcode and immediate of ADD A,0x01 with A=0xFF -> byte accepted only when valid&&ready, reg_a=0x00, reg_f=0xB0.
- rst asserted during WAIT of ADD A,B -> next cycle all registers 0x00, state FETCH, no writeback after reset release.
